// File: rtl/sclock_gen_if.sv
// Control and status bundle for sclock_gen: enable/clear/fast-mode inputs and
// the derived seconds waveforms plus phase counter.
interface sclock_gen_if #(
  parameter int CW = 25
);
  logic          en;
  logic          sync_clr;
  logic          fast;
  logic          clk_1hz;
  logic          tick_1hz;
  logic          blink_2hz;
  logic [CW-1:0] phase;

  modport master (
    output en, sync_clr, fast,
    input  clk_1hz, tick_1hz, blink_2hz, phase
  );

  modport slave (
    input  en, sync_clr, fast,
    output clk_1hz, tick_1hz, blink_2hz, phase
  );
endinterface

// File: rtl/sclock_gen.sv
// Seconds timebase: divides the board clock into a 1 Hz square wave, tick and
// 2 Hz blink strobe. Define SCLOCK_FAST_EN to enable the fast-set divider.
module sclock_gen #(
  parameter int CLK_HZ   = 27_000_000,
  parameter int TICK_HZ  = 1,
  parameter int FAST_MUL = 60
) (
  input  logic         clk_27Mhz,
  input  logic         reset_n,
  sclock_gen_if.slave  bus
);
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_F = DIV / FAST_MUL;
  localparam int CW    = $clog2(DIV);

  if (DIV < 8) begin : g_chk_div_min
    $error("sclock_gen: DIV must be >= 8");
  end
  if (DIV % 4 != 0) begin : g_chk_div_q
    $error("sclock_gen: DIV must be a multiple of 4");
  end
  if (DIV % FAST_MUL != 0) begin : g_chk_div_f
    $error("sclock_gen: DIV must be a multiple of FAST_MUL");
  end
  if (DIV_F < 4) begin : g_chk_divf_min
    $error("sclock_gen: DIV_F must be >= 4");
  end

  localparam logic [CW-1:0] PH_ONE = CW'(1'b1);
  localparam logic [CW-1:0] TERM_N = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_N = CW'(DIV / 2);
  localparam logic [CW-1:0] QTR_N  = CW'(DIV / 4);
`ifdef SCLOCK_FAST_EN
  localparam logic [CW-1:0] TERM_F = CW'(DIV_F - 1);
  localparam logic [CW-1:0] HALF_F = CW'(DIV_F / 2);
  localparam logic [CW-1:0] QTR_F  = CW'(DIV_F / 4);
`endif

  logic [CW-1:0] phase_r;
  logic          clk_r;
  logic          tick_r;
  logic          blink_r;

  logic [CW-1:0] term_s;
  logic [CW-1:0] half_s;
  logic [CW-1:0] qtr_s;
  logic          wrap_s;
  logic [CW-1:0] phase_nx_s;
  logic [CW-1:0] fold_s;
  logic          clk_nx_s;
  logic          blink_nx_s;

  // Next phase and the waveforms it implies; >= on TERM also catches an
  // out-of-range phase left over from a switch into fast mode.
  always_comb begin
    term_s = TERM_N;
    half_s = HALF_N;
    qtr_s  = QTR_N;
`ifdef SCLOCK_FAST_EN
    if (bus.fast) begin
      term_s = TERM_F;
      half_s = HALF_F;
      qtr_s  = QTR_F;
    end else begin
      term_s = TERM_N;
      half_s = HALF_N;
      qtr_s  = QTR_N;
    end
`endif
    wrap_s = (phase_r >= term_s);
    if (wrap_s) begin
      phase_nx_s = '0;
    end else begin
      phase_nx_s = phase_r + PH_ONE;
    end
    // phase_nx_s never exceeds TERM, so mod HALF is a single conditional subtract
    if (phase_nx_s >= half_s) begin
      clk_nx_s = 1'b1;
      fold_s   = phase_nx_s - half_s;
    end else begin
      clk_nx_s = 1'b0;
      fold_s   = phase_nx_s;
    end
    blink_nx_s = (fold_s >= qtr_s);
  end

  // Phase counter and registered outputs; clear beats enable.
  always_ff @(posedge clk_27Mhz or negedge reset_n) begin
    if (!reset_n) begin
      phase_r <= '0;
      clk_r   <= 1'b0;
      tick_r  <= 1'b0;
      blink_r <= 1'b0;
    end else if (bus.sync_clr) begin
      phase_r <= '0;
      clk_r   <= 1'b0;
      tick_r  <= 1'b0;
      blink_r <= 1'b0;
    end else if (bus.en) begin
      phase_r <= phase_nx_s;
      clk_r   <= clk_nx_s;
      tick_r  <= wrap_s;
      blink_r <= blink_nx_s;
    end else begin
      tick_r  <= 1'b0;
    end
  end

  assign bus.phase     = phase_r;
  assign bus.clk_1hz   = clk_r;
  assign bus.tick_1hz  = tick_r;
  assign bus.blink_2hz = blink_r;
endmodule

// File: doc/sclock_gen.md
Name: sclock_gen

Overview:
- Parametrised successor to the fixed 1 Hz divider in the watch timebase.
- Derives a 50%-duty seconds square wave, a one-cycle seconds tick, a 2 Hz blink strobe for the set-mode display and the phase counter, all from the board clock.
- Adds enable, synchronous clear (seconds alignment when the user sets time) and a fast-set mode.
- Sits between the board clock and the hh:mm:ss counter / display blanking logic.

Parameters:
CLK_HZ, 27_000_000, input clock frequency in Hz
TICK_HZ, 1, output tick frequency in Hz; DIV = CLK_HZ/TICK_HZ
FAST_MUL, 60, speed-up factor in fast mode; DIV_F = DIV/FAST_MUL
CW, $clog2(CLK_HZ/TICK_HZ), phase counter width (derived, do not override)

Ports:
clk_27Mhz  in  1  board clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
en  in  1  count enable; 0 freezes phase and all outputs
sync_clr  in  1  synchronous clear of phase/outputs, priority over en
fast  in  1  fast-set mode select (used only with SCLOCK_FAST_EN)
clk_1hz  out  1  registered square wave, period DIV (or DIV_F) cycles
tick_1hz  out  1  registered one-cycle pulse per period
blink_2hz  out  1  registered square wave at twice the clk_1hz rate
phase  out  CW  current counter value, 0..TERM

Behaviour:
- Elaboration checks: DIV >= 8, DIV % 4 == 0, DIV % FAST_MUL == 0, DIV_F >= 4; otherwise $error.
- Reset (reset_n=0, async assert, sync release): phase=0, clk_1hz=0, tick_1hz=0, blink_2hz=0.
- TERM = DIV-1 normally; DIV_F-1 when fast mode active. HALF = (TERM+1)/2, QTR = (TERM+1)/4.
- Each edge, priority order:
  - sync_clr=1: phase=0, all outputs 0.
  - else en=0: hold phase, clk_1hz, blink_2hz; tick_1hz=0.
  - else phase_next = (phase >= TERM) ? 0 : phase+1.
- Out-of-range phase (fast asserted while phase > TERM): phase wraps to 0 on the next enabled edge. That edge counts as a wrap.
- Outputs are registered from phase_next, so they are aligned with the phase they describe:
  - clk_1hz = (phase_next >= HALF)
  - tick_1hz = 1 exactly on edges where phase wraps to 0 via the counting path, never after reset or sync_clr
  - blink_2hz = (phase_next mod HALF) >= QTR
- Latency: the first tick occurs DIV enabled edges after reset release or clear.
- Duty: clk_1hz low for HALF cycles, high for TERM+1-HALF cycles.
- Arithmetic unsigned, width CW; no overflow possible since TERM < 2^CW.
- Reset asserted mid-period: immediate return to reset values, no glitch pulse on tick_1hz.
- sync_clr and en both high: clear wins. sync_clr held: phase stays 0, outputs stay 0.

Optional Feature:
SCLOCK_FAST_EN
- Defined: fast=1 selects TERM = DIV_F-1. clk_1hz, tick_1hz and blink_2hz all run FAST_MUL times faster, for rapid minute/hour setting. Mode switches take effect on the next edge with the out-of-range rule above.
- Not defined: fast port is present but ignored; TERM is always DIV-1; no DIV_F comparator is synthesised.

Test Plan:
- CLK_HZ=40, TICK_HZ=1, en=1, release reset -> phase 0..39 repeating. tick_1hz high only on edges 40, 80, ... clk_1hz low 20 / high 20. blink_2hz period 20 with 10 high.
- Same config, drop en at phase=17 for 5 cycles -> phase holds 17, clk_1hz/blink_2hz hold, no tick. Count resumes at 18; next tick is 23 enabled edges later.
- Assert sync_clr at phase=33 together with en=1 -> next phase=0, all outputs 0, no tick. Next tick after 40 enabled cycles.
- Assert reset_n=0 asynchronously at phase=39 -> outputs 0 before the next edge, no tick emitted. After release, first tick 40 edges later.
- With SCLOCK_FAST_EN, FAST_MUL=4 (DIV_F=10): fast=1 at phase=25 -> wrap to 0 with tick on the next edge, then tick every 10 cycles. fast=0 -> period returns to 40.
- Without SCLOCK_FAST_EN, toggle fast randomly -> waveforms identical to the fast=0 run.
